// File: rtl/compositor_pkg.sv
// Shared constants, pixel types and the palette-to-8-bit channel expansion
// used across the sprite compositor.
package compositor_pkg;

    localparam int         DEFAULT_COORD_W = 10;
    localparam int         DEFAULT_COLOR_W = 4;
    localparam logic [3:0] BG_INDEX        = 4'hF;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // The palette value sits right-aligned in c; it is repeated from the MSB
    // down so that all-ones stays all-ones and zero stays zero.
    function automatic logic [7:0] expand_channel(input logic [7:0] c, input int width);
        logic [7:0] result;
        result = '0;
        for (int b = 0; b < 8; b++) begin
            result[7 - b] = c[width - 1 - (b % width)];
        end
        return result;
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel-stream bundle between the video timing / sprite source (master) and
// the compositor (slave).
interface sprite_compositor_if #(
    parameter int NUM_LAYERS = 2,
    parameter int COORD_W    = compositor_pkg::DEFAULT_COORD_W,
    parameter int COLOR_W    = compositor_pkg::DEFAULT_COLOR_W
);

    logic                          frame_start;
    logic [COORD_W-1:0]            DrawX;
    logic [COORD_W-1:0]            DrawY;
    logic                          blank;
    logic [NUM_LAYERS*COORD_W-1:0] layer_x;
    logic [NUM_LAYERS*COORD_W-1:0] layer_y;
    logic [NUM_LAYERS-1:0]         layer_en;
    logic [NUM_LAYERS*COLOR_W-1:0] layer_r;
    logic [NUM_LAYERS*COLOR_W-1:0] layer_g;
    logic [NUM_LAYERS*COLOR_W-1:0] layer_b;
    logic [COLOR_W-1:0]            bg_r;
    logic [COLOR_W-1:0]            bg_g;
    logic [COLOR_W-1:0]            bg_b;
    logic [7:0]                    Red;
    logic [7:0]                    Green;
    logic [7:0]                    Blue;
    logic [3:0]                    hit_layer;
    logic [NUM_LAYERS-1:0]         collision;

    modport master (
        output frame_start, DrawX, DrawY, blank,
        output layer_x, layer_y, layer_en, layer_r, layer_g, layer_b,
        output bg_r, bg_g, bg_b,
        input  Red, Green, Blue, hit_layer, collision
    );

    modport slave (
        input  frame_start, DrawX, DrawY, blank,
        input  layer_x, layer_y, layer_en, layer_r, layer_g, layer_b,
        input  bg_r, bg_g, bg_b,
        output Red, Green, Blue, hit_layer, collision
    );

endinterface

// File: rtl/sprite_layer_hit.sv
// Per-layer bounding-box and opacity test for the current pixel (purely
// combinational; the caller registers the result).
module sprite_layer_hit #(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 4,
    parameter int LAYER_W = 32,
    parameter int LAYER_H = 32
) (
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic               en,
    input  logic [COLOR_W-1:0] r,
    input  logic [COLOR_W-1:0] g,
    input  logic [COLOR_W-1:0] b,
    output logic               opaque
);

    localparam logic [COORD_W:0] BOX_W = (COORD_W + 1)'(LAYER_W);
    localparam logic [COORD_W:0] BOX_H = (COORD_W + 1)'(LAYER_H);

    logic [COORD_W:0] dx;
    logic [COORD_W:0] dy;
    logic             in_box;

    // The extra top bit catches the borrow, so pixels left of or above the
    // corner never match a sprite that has been pushed past the screen edge.
    assign dx     = {1'b0, draw_x} - {1'b0, pos_x};
    assign dy     = {1'b0, draw_y} - {1'b0, pos_y};
    assign in_box = (dx < BOX_W) && (dy < BOX_H);

    assign opaque = en && in_box && (r != '1) && (g != '1) && (b != '1);

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: per-layer hit tests, lowest-index-wins priority
// mux over the background, and per-frame layer collision flags.
module sprite_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int COORD_W    = DEFAULT_COORD_W,
    parameter int COLOR_W    = DEFAULT_COLOR_W,
    parameter int LAYER_W    = 32,
    parameter int LAYER_H    = 32
) (
    input logic                vga_clk,
    input logic                reset_n,
    sprite_compositor_if.slave bus
);

    logic [NUM_LAYERS*COORD_W-1:0] shadow_x, shadow_y, cur_x, cur_y;
    logic [NUM_LAYERS-1:0]         shadow_en, cur_en, opaque;

    logic [NUM_LAYERS-1:0]         s1_opaque;
    logic                          s1_blank;
    logic [NUM_LAYERS*COLOR_W-1:0] s1_layer_r, s1_layer_g, s1_layer_b;
    logic [COLOR_W-1:0]            s1_bg_r, s1_bg_g, s1_bg_b;

    logic [3:0]                    win_idx, hit_d, hit_q;
    logic [COLOR_W-1:0]            win_r, win_g, win_b;
    rgb_t                          pix_d, pix_q;

    logic [NUM_LAYERS-1:0]         overlap_hits, sticky, collision_q;

    // The frame_start pixel already belongs to the new frame, so it sees the
    // incoming positions directly rather than the not-yet-loaded shadows.
    assign cur_x  = bus.frame_start ? bus.layer_x  : shadow_x;
    assign cur_y  = bus.frame_start ? bus.layer_y  : shadow_y;
    assign cur_en = bus.frame_start ? bus.layer_en : shadow_en;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_x  <= '0;
            shadow_y  <= '0;
            shadow_en <= '0;
        end else if (bus.frame_start) begin
            shadow_x  <= bus.layer_x;
            shadow_y  <= bus.layer_y;
            shadow_en <= bus.layer_en;
        end
    end

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        sprite_layer_hit #(
            .COORD_W (COORD_W),
            .COLOR_W (COLOR_W),
            .LAYER_W (LAYER_W),
            .LAYER_H (LAYER_H)
        ) u_hit (
            .draw_x (bus.DrawX),
            .draw_y (bus.DrawY),
            .pos_x  (cur_x[i*COORD_W +: COORD_W]),
            .pos_y  (cur_y[i*COORD_W +: COORD_W]),
            .en     (cur_en[i]),
            .r      (bus.layer_r[i*COLOR_W +: COLOR_W]),
            .g      (bus.layer_g[i*COLOR_W +: COLOR_W]),
            .b      (bus.layer_b[i*COLOR_W +: COLOR_W]),
            .opaque (opaque[i])
        );
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_opaque  <= '0;
            s1_blank   <= 1'b0;
            s1_layer_r <= '0;
            s1_layer_g <= '0;
            s1_layer_b <= '0;
            s1_bg_r    <= '0;
            s1_bg_g    <= '0;
            s1_bg_b    <= '0;
        end else begin
            s1_opaque  <= opaque;
            s1_blank   <= bus.blank;
            s1_layer_r <= bus.layer_r;
            s1_layer_g <= bus.layer_g;
            s1_layer_b <= bus.layer_b;
            s1_bg_r    <= bus.bg_r;
            s1_bg_g    <= bus.bg_g;
            s1_bg_b    <= bus.bg_b;
        end
    end

    // Scanning from the top index down leaves the lowest opaque layer in place.
    always_comb begin
        win_idx = BG_INDEX;
        win_r   = s1_bg_r;
        win_g   = s1_bg_g;
        win_b   = s1_bg_b;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_opaque[i]) begin
                win_idx = 4'(i);
                win_r   = s1_layer_r[i*COLOR_W +: COLOR_W];
                win_g   = s1_layer_g[i*COLOR_W +: COLOR_W];
                win_b   = s1_layer_b[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_comb begin
        pix_d = '0;
        hit_d = BG_INDEX;
        if (s1_blank) begin
            pix_d.r = expand_channel(8'(win_r), COLOR_W);
            pix_d.g = expand_channel(8'(win_g), COLOR_W);
            pix_d.b = expand_channel(8'(win_b), COLOR_W);
            hit_d   = win_idx;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_q <= '0;
            hit_q <= BG_INDEX;
        end else begin
            pix_q <= pix_d;
            hit_q <= hit_d;
        end
    end

    always_comb begin
        overlap_hits = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            overlap_hits[i] = s1_blank && s1_opaque[i]
                              && ((s1_opaque & ~(NUM_LAYERS'(1) << i)) != '0);
        end
    end

    // At frame_start the stage-1 flags still hold the last pixel of the old
    // frame, so they are folded into the reported flags, not the new sticky set.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky      <= '0;
            collision_q <= '0;
        end else if (bus.frame_start) begin
            collision_q <= sticky | overlap_hits;
            sticky      <= '0;
        end else begin
            sticky      <= sticky | overlap_hits;
        end
    end

    assign bus.Red       = pix_q.r;
    assign bus.Green     = pix_q.g;
    assign bus.Blue      = pix_q.b;
    assign bus.hit_layer = hit_q;
    assign bus.collision = collision_q;

endmodule
